// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer for the fetch stage
//
// Purpose:
//   Looks up the fetch PC every cycle and returns a predicted next PC. Entries
//   (valid, tag, target, 2-bit saturating counter) are trained by resolved-branch
//   feedback from EX. Lookup is combinational; updates land on the next edge.
//
// Configuration macro:
//   BTB_BYPASS_EN - when defined, a same-cycle update to the looked-up index is
//                   forwarded to the lookup outputs (not while i_flush is high).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_lookup_valid      fetch PC valid
//   i_lookup_pc         fetch PC (word aligned)
//   o_hit               valid entry with matching tag
//   o_prediction        TAKEN iff hit and counter msb set
//   o_next_pc           predicted next fetch PC
//   i_upd_valid         EX feedback valid
//   i_upd_pc            PC of resolved branch/jump
//   i_upd_target        resolved target
//   i_upd_outcome       resolved outcome
//   i_upd_is_jump       update is an unconditional jump
//   i_flush             invalidate all entries

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_lookup_valid,
    input  logic [`ADDR_WIDTH-1:0]          i_lookup_pc,
    output logic                            o_hit,
    output mips_core_pkg::BranchOutcome     o_prediction,
    output logic [`ADDR_WIDTH-1:0]          o_next_pc,
    input  logic                            i_upd_valid,
    input  logic [`ADDR_WIDTH-1:0]          i_upd_pc,
    input  logic [`ADDR_WIDTH-1:0]          i_upd_target,
    input  mips_core_pkg::BranchOutcome     i_upd_outcome,
    input  logic                            i_upd_is_jump,
    input  logic                            i_flush
);
    import mips_core_pkg::*;

    localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_W      = `ADDR_WIDTH - INDEX_BITS - 2;

    logic [ENTRIES-1:0]     valid_q;
    logic [TAG_W-1:0]       tag_q    [ENTRIES];
    logic [`ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]             ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0]  lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic [INDEX_BITS-1:0]  upd_idx;
    logic [TAG_W-1:0]       upd_tag;
    logic                   upd_hit;
    logic                   upd_taken;

    // Next value of the entry at upd_idx
    logic                   wr_en;
    logic [TAG_W-1:0]       tag_d;
    logic [`ADDR_WIDTH-1:0] target_d;
    logic [1:0]             ctr_d;

    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [`ADDR_WIDTH-1:0] rd_target;
    logic [1:0]             rd_ctr;
    logic                   pred_taken;

    // Byte-offset bits never participate in index or tag
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign lk_idx    = i_lookup_pc[INDEX_BITS+1:2];
    assign lk_tag    = i_lookup_pc[`ADDR_WIDTH-1:INDEX_BITS+2];
    assign upd_idx   = i_upd_pc[INDEX_BITS+1:2];
    assign upd_tag   = i_upd_pc[`ADDR_WIDTH-1:INDEX_BITS+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_taken = (i_upd_outcome == TAKEN);

    always_comb begin
        wr_en    = 1'b0;
        tag_d    = upd_tag;
        target_d = target_q[upd_idx];
        ctr_d    = ctr_q[upd_idx];
        if (i_upd_valid) begin
            if (!upd_hit) begin
                // Not-taken misses are not worth an entry; taken misses replace
                if (upd_taken) begin
                    wr_en    = 1'b1;
                    target_d = i_upd_target;
                    ctr_d    = i_upd_is_jump ? 2'b11 : 2'b10;
                end
            end else begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    target_d = i_upd_target;
                    if (i_upd_is_jump || ctr_q[upd_idx] == 2'b11) begin
                        ctr_d = 2'b11;
                    end else begin
                        ctr_d = ctr_q[upd_idx] + 2'd1;
                    end
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d = ctr_q[upd_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (i_flush) begin
            // Flush wins: any update in the same cycle is dropped
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= tag_d;
            target_q[upd_idx] <= target_d;
            ctr_q[upd_idx]    <= ctr_d;
        end
    end

`ifdef BTB_BYPASS_EN
    logic fwd;
    assign fwd = wr_en && !i_flush && (upd_idx == lk_idx);

    always_comb begin
        rd_valid  = valid_q[lk_idx];
        rd_tag    = tag_q[lk_idx];
        rd_target = target_q[lk_idx];
        rd_ctr    = ctr_q[lk_idx];
        if (fwd) begin
            rd_valid  = 1'b1;
            rd_tag    = tag_d;
            rd_target = target_d;
            rd_ctr    = ctr_d;
        end
    end
`else
    always_comb begin
        rd_valid  = valid_q[lk_idx];
        rd_tag    = tag_q[lk_idx];
        rd_target = target_q[lk_idx];
        rd_ctr    = ctr_q[lk_idx];
    end
`endif

    assign o_hit        = i_lookup_valid && rd_valid && (rd_tag == lk_tag);
    assign pred_taken   = o_hit && rd_ctr[1];
    assign o_prediction = pred_taken ? TAKEN : NOT_TAKEN;
    assign o_next_pc    = pred_taken ? rd_target : (i_lookup_pc + `ADDR_WIDTH'(4));

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_target_buffer;
    import mips_core_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_lookup_valid = 1'b0;
    logic [`ADDR_WIDTH-1:0] i_lookup_pc = '0;
    logic                   o_hit;
    BranchOutcome           o_prediction;
    logic [`ADDR_WIDTH-1:0] o_next_pc;
    logic                   i_upd_valid = 1'b0;
    logic [`ADDR_WIDTH-1:0] i_upd_pc = '0;
    logic [`ADDR_WIDTH-1:0] i_upd_target = '0;
    BranchOutcome           i_upd_outcome = NOT_TAKEN;
    logic                   i_upd_is_jump = 1'b0;
    logic                   i_flush = 1'b0;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_lookup_valid(i_lookup_valid), .i_lookup_pc(i_lookup_pc),
        .o_hit(o_hit), .o_prediction(o_prediction), .o_next_pc(o_next_pc),
        .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target),
        .i_upd_outcome(i_upd_outcome), .i_upd_is_jump(i_upd_is_jump), .i_flush(i_flush)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model: one record per set, PC split by plain arithmetic
    typedef struct {
        bit          valid;
        int unsigned tag;
        logic [31:0] target;
        int          ctr;
    } ent_t;
    ent_t model [16];

    function automatic int unsigned pc_idx(logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int unsigned pc_tag(logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic ent_t trained(ent_t e, logic [31:0] upc, logic [31:0] tgt, bit taken, bit jmp);
        ent_t r = e;
        bit hit = e.valid && (e.tag == pc_tag(upc));
        if (!hit) begin
            if (taken) begin
                r.valid = 1; r.tag = pc_tag(upc); r.target = tgt; r.ctr = jmp ? 3 : 2;
            end
        end else if (taken) begin
            r.target = tgt;
            r.ctr = jmp ? 3 : ((e.ctr + 1 > 3) ? 3 : e.ctr + 1);
        end else begin
            r.ctr = (e.ctr - 1 < 0) ? 0 : e.ctr - 1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            model[i].valid = 0; model[i].tag = 0; model[i].target = '0; model[i].ctr = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare mid-cycle, then advance model at the edge.
    // use_exp selects fixed expectations; otherwise the model supplies them.
    task automatic run_cycle(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                             input logic [31:0] utgt, input bit utaken, input bit ujmp, input bit fl,
                             input bit use_exp, input bit x_hit, input bit x_taken,
                             input logic [31:0] x_next, input string name);
        ent_t e;
        bit   e_hit, e_taken;
        logic [31:0] e_next;
        i_lookup_valid = lv; i_lookup_pc = lpc;
        i_upd_valid = uv; i_upd_pc = upc; i_upd_target = utgt;
        i_upd_outcome = utaken ? TAKEN : NOT_TAKEN; i_upd_is_jump = ujmp; i_flush = fl;
        @(negedge clk);
        if (use_exp) begin
            e_hit = x_hit; e_taken = x_taken; e_next = x_next;
        end else begin
            e = model[pc_idx(lpc)];
`ifdef BTB_BYPASS_EN
            if (uv && !fl && pc_idx(upc) == pc_idx(lpc)) e = trained(e, upc, utgt, utaken, ujmp);
`endif
            e_hit   = lv && e.valid && (e.tag == pc_tag(lpc));
            e_taken = e_hit && (e.ctr >= 2);
            e_next  = e_taken ? e.target : lpc + 32'd4;
        end
        check({name, "_hit"}, 32'(o_hit), 32'(e_hit));
        check({name, "_pred"}, 32'(o_prediction == TAKEN), 32'(e_taken));
        check({name, "_next"}, o_next_pc, e_next);
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 16; i++) model[i].valid = 0;
        end else if (uv) begin
            model[pc_idx(upc)] = trained(model[pc_idx(upc)], upc, utgt, utaken, ujmp);
        end
        #1;
    endtask

    typedef struct {
        bit lv; logic [31:0] lpc;
        bit uv; logic [31:0] upc; logic [31:0] utgt; bit utaken; bit ujmp; bit fl;
        bit hit; bit taken; logic [31:0] next;
    } vec_t;

    function automatic vec_t mk(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, logic [31:0] utgt,
                                bit utaken, bit ujmp, bit fl, bit hit, bit taken, logic [31:0] next);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.utgt = utgt; v.utaken = utaken;
        v.ujmp = ujmp; v.fl = fl; v.hit = hit; v.taken = taken; v.next = next;
        return v;
    endfunction

    localparam logic [31:0] IDLE_PC = 32'h0040_0004;
    localparam logic [31:0] IDLE_NX = 32'h0040_0008;

    vec_t vecs [27];

    initial begin
        // Idle lookups use set 1, which the directed rows never train
        vecs[0]  = mk(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004);
        vecs[1]  = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0040_0100, 1, 0, 0, 0, 0, IDLE_NX);
        vecs[2]  = mk(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0100);
        vecs[3]  = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0, 0, 0, 0, 0, 0, IDLE_NX);
        vecs[4]  = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0, 0, 0, 0, 0, 0, IDLE_NX);
        vecs[5]  = mk(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0014);
        vecs[6]  = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0040_0100, 1, 0, 0, 0, 0, IDLE_NX);
        vecs[7]  = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0040_0100, 1, 0, 0, 0, 0, IDLE_NX);
        vecs[8]  = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0040_0100, 1, 0, 0, 0, 0, IDLE_NX);
        vecs[9]  = mk(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0100);
        vecs[10] = mk(1, IDLE_PC, 1, 32'h0040_0010, 32'h0, 0, 0, 0, 0, 0, IDLE_NX);
        vecs[11] = mk(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0100);
        vecs[12] = mk(1, IDLE_PC, 1, 32'h0040_0050, 32'h0040_0500, 1, 0, 0, 0, 0, IDLE_NX);
        vecs[13] = mk(1, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0014);
        vecs[14] = mk(1, 32'h0040_0050, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0500);
        vecs[15] = mk(1, IDLE_PC, 1, 32'h0040_0090, 32'h0040_0900, 0, 0, 0, 0, 0, IDLE_NX);
        vecs[16] = mk(1, 32'h0040_0050, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0500);
        vecs[17] = mk(1, 32'h0040_0090, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0094);
        vecs[18] = mk(1, IDLE_PC, 1, 32'h0040_0030, 32'h0040_0300, 1, 0, 1, 0, 0, IDLE_NX);
        vecs[19] = mk(1, 32'h0040_0030, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0034);
        vecs[20] = mk(1, 32'h0040_0050, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0054);
        vecs[21] = mk(1, IDLE_PC, 1, 32'h0040_0040, 32'h0040_0800, 1, 1, 0, 0, 0, IDLE_NX);
        vecs[22] = mk(1, 32'h0040_0040, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0800);
        vecs[23] = mk(1, IDLE_PC, 1, 32'h0040_0040, 32'h0, 0, 0, 0, 0, 0, IDLE_NX);
        vecs[24] = mk(1, 32'h0040_0040, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0800);
        vecs[25] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
        vecs[26] = mk(0, 32'h0040_0040, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0044);

        model_reset();

        // Outputs while reset is asserted
        i_lookup_valid = 1; i_lookup_pc = 32'h0040_0000;
        #3;
        check("rst_hit", 32'(o_hit), 32'd0);
        check("rst_pred", 32'(o_prediction == TAKEN), 32'd0);
        check("rst_next", o_next_pc, 32'h0040_0004);
        @(posedge clk); #1;
        rst_n = 1;

        foreach (vecs[i]) begin
            run_cycle(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].utaken,
                      vecs[i].ujmp, vecs[i].fl, 1, vecs[i].hit, vecs[i].taken, vecs[i].next,
                      $sformatf("vec%0d", i));
        end

        // Reset in the middle of operation drops everything trained so far
        run_cycle(1, IDLE_PC, 1, 32'h0040_0060, 32'h0040_0600, 1, 0, 0, 1, 0, 0, IDLE_NX, "mr_train");
        run_cycle(1, 32'h0040_0060, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0040_0600, "mr_pre");
        i_lookup_valid = 1; i_lookup_pc = 32'h0040_0060; i_upd_valid = 0; i_flush = 0;
        #2 rst_n = 0;
        #1;
        check("mr_hit", 32'(o_hit), 32'd0);
        check("mr_next", o_next_pc, 32'h0040_0064);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        run_cycle(1, 32'h0040_0060, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0040_0064, "mr_post");

        // Same-cycle lookup and update of the same PC
`ifdef BTB_BYPASS_EN
        run_cycle(1, 32'h0040_0020, 1, 32'h0040_0020, 32'h0040_0200, 1, 0, 0, 1, 1, 1, 32'h0040_0200, "byp_same");
`else
        run_cycle(1, 32'h0040_0020, 1, 32'h0040_0020, 32'h0040_0200, 1, 0, 0, 1, 0, 0, 32'h0040_0024, "byp_same");
`endif
        run_cycle(1, 32'h0040_0020, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0040_0200, "byp_next");
        // Flush suppresses forwarding and the update itself
        run_cycle(1, 32'h0040_0030, 1, 32'h0040_0030, 32'h0040_0300, 1, 0, 1, 1, 0, 0, 32'h0040_0034, "byp_flush");
        run_cycle(1, 32'h0040_0030, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0040_0034, "byp_flush_next");

        // Randomized traffic over a small PC pool (4 tags per set) against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lpc, upc, tgt;
            bit lv, uv, tk, jp, fl;
            lpc = 32'h0040_0000 + ($urandom_range(0, 63) << 2);
            upc = 32'h0040_0000 + ($urandom_range(0, 63) << 2);
            tgt = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            lv  = ($urandom_range(0, 9) != 0);
            uv  = ($urandom_range(0, 9) < 7);
            tk  = ($urandom_range(0, 2) != 0);
            jp  = tk && ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) lpc = upc;
            run_cycle(lv, lpc, uv, upc, tgt, tk, jp, fl, 0, 0, 0, 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
